// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit.
//
// Executes MULT (op[0]=0) and DIV (op[0]=1) on WIDTH-bit operands using a
// shift-add multiplier and a restoring divider that share one accumulator.
// Both operations take WIDTH iteration cycles plus one sign-fix cycle, so
// done pulses WIDTH+1 cycles after the start edge.
//
// Optional feature: define MULT_DIV_UNSIGNED_EN to let op[1]=1 select
// MULTU/DIVU (no sign handling). Without the macro op[1] is ignored.
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high
//   start     one-cycle request, sampled only in the idle state
//   op        op[0]: 0=mult, 1=div; op[1]: unsigned select (optional)
//   a, b      rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   busy      high while an operation is in progress
//   done      one-cycle pulse when hi/lo (or div_zero) are valid
//   div_zero  one-cycle pulse with done on divide by zero
//   hi, lo    mult: product high/low; div: remainder/quotient
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMultRun, StDivRun, StFix} state_t;

  state_t           state;
  logic [CntW-1:0]  count;
  // mult: {partial product (W+1), multiplier}; div: {remainder (W+1), quotient}
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic             is_div;
  logic             sign_a;
  logic             neg_res;

  logic signed_op;
`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_op = ~op[1];
`else
  logic unused_op_hi;
  assign signed_op    = 1'b1;
  assign unused_op_hi = op[1];
`endif

  // Operand magnitudes; -2^(W-1) maps to unsigned 2^(W-1), which fits in W bits.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration of each datapath.
  logic [WIDTH:0]   mult_sum;
  logic [2*WIDTH:0] mult_step;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [2*WIDTH:0] div_step;

  always_comb begin
    mult_sum  = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
    mult_step = acc[0] ? ({mult_sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd};
    // Restore (keep shifted value) when the trial subtraction goes negative.
    div_step  = div_trial[WIDTH+1] ? {div_shift, acc[WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up applied in the final cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // Remainder follows the dividend (truncating division).
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= StIdle;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      neg_res  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (op[0] && (b == '0)) begin
              // Divide by zero: flag immediately, results untouched.
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              is_div  <= op[0];
              sign_a  <= a_neg;
              neg_res <= a_neg ^ b_neg;
              opnd    <= op[0] ? b_mag : a_mag;
              acc     <= {{(WIDTH + 1){1'b0}}, (op[0] ? a_mag : b_mag)};
              count   <= CntW'(WIDTH);
              busy    <= 1'b1;
              state   <= op[0] ? StDivRun : StMultRun;
            end
          end
        end
        StMultRun: begin
          acc   <= mult_step;
          count <= count - 1'b1;
          if (count == CntW'(1)) state <= StFix;
        end
        StDivRun: begin
          acc   <= div_step;
          count <= count - 1'b1;
          if (count == CntW'(1)) state <= StFix;
        end
        StFix: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32). Expected results are
// queued when an operation is started and compared when done pulses.
module tb_mult_div_unit;

  localparam int unsigned WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model built from language arithmetic (truncating / and %).
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy;
    logic [63:0] p;
    if (o[1]) begin
      sx = longint'({32'h0, x});
      sy = longint'({32'h0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    e.dz = 1'b0;
    if (o[0]) begin
      p    = 64'(sx / sy);
      e.lo = p[31:0];
      p    = 64'(sx % sy);
      e.hi = p[31:0];
    end else begin
      p    = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, no operation pending", hi, lo);
      end else begin
        e = sb_q.pop_front();
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
          $display("FAIL result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                   hi, lo, div_zero, e.hi, e.lo, e.dz);
        else
          n_pass++;
      end
    end
  end

  // Drive a start pulse at the current negedge; returns at the next negedge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input exp_t e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Count negedges until done (bounded); also counts cycles busy was seen high.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b want 0", div_zero); else n_pass++;
    n_total++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
  endtask

  task automatic test_signed_mult;
    int cyc, bcyc;
    start_op(2'b00, 32'd7, 32'hFFFF_FFFD, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL mult_latency: got %0d want 33", cyc); else n_pass++;
    n_total++; if (bcyc !== 33) $display("FAIL mult_busy_cycles: got %0d want 33", bcyc); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b want 0", busy); else n_pass++;
    @(negedge clock);
    n_total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_signed_div;
    int cyc, bcyc;
    start_op(2'b01, 32'hFFFF_FFF9, 32'd2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL div_latency: got %0d want 33", cyc); else n_pass++;
    @(negedge clock);
    start_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'h0, lo: 32'h8000_0000, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL div_ovf_latency: got %0d want 33", cyc); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_div_zero;
    int cyc, bcyc;
    start_op(2'b01, 32'h1234_5678, 32'h7FFF_FFFF, '{hi: 32'h1234_5678, lo: 32'h0, dz: 1'b0});
    wait_done(cyc, bcyc);
    @(negedge clock);
    start_op(2'b01, 32'd55, 32'h0, '{hi: 32'h1234_5678, lo: 32'h0, dz: 1'b1});
    n_total++; if (done !== 1'b1) $display("FAIL dz_done: got %b want 1", done); else n_pass++;
    n_total++; if (div_zero !== 1'b1) $display("FAIL dz_flag: got %b want 1", div_zero); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL dz_busy: got %b want 0", busy); else n_pass++;
    @(negedge clock);
    n_total++;
    if ({done, div_zero, busy} !== 3'b000)
      $display("FAIL dz_after: got done/dz/busy=%b want 000", {done, div_zero, busy});
    else n_pass++;
    n_total++; if (hi !== 32'h1234_5678) $display("FAIL dz_hi_hold: got %h want 12345678", hi); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    start_op(2'b00, 32'd3, 32'd4, '{hi: 32'h0, lo: 32'd12, dz: 1'b0});
    repeat (4) @(negedge clock);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd100;
    b     = 32'd100;
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 28) $display("FAIL busy_start_latency: got %0d want 28", cyc); else n_pass++;
    // Start on the done cycle must be accepted.
    start_op(2'b01, 32'hFFFF_FF9C, 32'd7, '{hi: 32'hFFFF_FFFE, lo: 32'hFFFF_FFF2, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL done_cycle_start_latency: got %0d want 33", cyc); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    int cyc, bcyc, ndone;
    start_op(2'b01, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_hilo: got %h_%h want 0", hi, lo); else n_pass++;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    n_total++; if (ndone !== 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", ndone); else n_pass++;
    start_op(2'b01, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL rst_mid_retry_latency: got %0d want 33", cyc); else n_pass++;
    @(negedge clock);
  endtask

`ifdef MULT_DIV_UNSIGNED_EN
  task automatic test_unsigned;
    int cyc, bcyc;
    start_op(2'b11, 32'hFFFF_FFFF, 32'd2, '{hi: 32'd1, lo: 32'h7FFF_FFFF, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL divu_latency: got %0d want 33", cyc); else n_pass++;
    @(negedge clock);
    start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{hi: 32'hFFFF_FFFE, lo: 32'h1, dz: 1'b0});
    wait_done(cyc, bcyc);
    n_total++; if (cyc !== 33) $display("FAIL multu_latency: got %0d want 33", cyc); else n_pass++;
    @(negedge clock);
  endtask
`endif

  task automatic test_random;
    int          cyc, bcyc;
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
`ifndef MULT_DIV_UNSIGNED_EN
      o[1] = 1'b0;
`endif
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) x = -x;
      if (y == 32'h0) y = 32'd1;
      start_op(o, x, y, model(o, x, y));
      wait_done(cyc, bcyc);
      n_total++;
      if (cyc !== 33) $display("FAIL rand_latency[%0d]: got %0d want 33", i, cyc); else n_pass++;
      if (i % 2 == 0) @(negedge clock);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    @(negedge clock);
    test_reset;
    test_signed_mult;
    test_signed_div;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
`ifdef MULT_DIV_UNSIGNED_EN
    test_unsigned;
`endif
    test_random;
    repeat (3) @(negedge clock);
    n_total++;
    if (sb_q.size() != 0) $display("FAIL pending_results: got %0d left want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
